// File: rtl/planet_emp_gen.sv
// planet_emp_gen: single-button missile-vs-rotating-empire game with tick-based timers and square-wave sound.
module planet_emp_gen #(
  parameter int C_PDIV_N     = 135,
  parameter int C_MSL_N      = 8,
  parameter int C_EMP_N      = 8,
  parameter int C_MSL_STEP_N = 150_000,
  parameter int C_EMP_STEP_N = 300_000,
  parameter int C_SND_HALF_N = 150,
  parameter int C_LONG_N     = 1_000_000,
  parameter int C_PLAY_MAX_N = 36_600_000
) (
  input  logic               CK_i,
  input  logic               ARST_i,
  input  logic               PSW_i,
  output logic [C_MSL_N-1:0] MSL_o,
  output logic [C_EMP_N-1:0] EMP_o,
  output logic [7:0]         SCORE_o,
  output logic [1:0]         STATE_o,
  output logic               SOUND_o
);
  function automatic int cw(input int n);
    int r;
    r = 1;
    while ((64'd1 << r) <= 64'(n)) r++;
    return r;
  endfunction

  localparam int PW = cw(C_PDIV_N - 1);
  localparam int MW = cw(C_MSL_STEP_N - 1);
  localparam int EW = cw(C_EMP_STEP_N - 1);
  localparam int SW = cw(C_SND_HALF_N - 1);
  localparam int LW = cw(C_LONG_N);
  localparam int TW = cw(C_PLAY_MAX_N - 1);
  localparam logic [PW-1:0] P_END = PW'(C_PDIV_N - 1);
  localparam logic [MW-1:0] M_END = MW'(C_MSL_STEP_N - 1);
  localparam logic [EW-1:0] E_END = EW'(C_EMP_STEP_N - 1);
  localparam logic [SW-1:0] S_END = SW'(C_SND_HALF_N - 1);
  localparam logic [LW-1:0] L_END = LW'(C_LONG_N);
  localparam logic [LW-1:0] L_PRE = LW'(C_LONG_N - 1);
  localparam logic [TW-1:0] T_END = TW'(C_PLAY_MAX_N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2, BAD = 2'd3} state_t;

  state_t             state, state_n;
  logic [PW-1:0]      pdiv, pdiv_n;
  logic [MW-1:0]      mt, mt_n;
  logic [EW-1:0]      et, et_n;
  logic [SW-1:0]      st, st_n;
  logic [LW-1:0]      lcnt, lcnt_n;
  logic [TW-1:0]      pt, pt_n;
  logic [C_MSL_N-1:0] msl, msl_n;
  logic [C_EMP_N-1:0] emp, emp_n, emp_h;
  logic [7:0]         score, score_n;
  logic               psw_q, snd, snd_n, tick, press, long_hit, fly;

  always_comb begin
    tick = pdiv == P_END;
    press = PSW_i & ~psw_q & (lcnt != L_END);
    long_hit = tick & PSW_i & (lcnt == L_PRE);
    fly = state == PLAY && msl != '0;
    pdiv_n = tick ? '0 : pdiv + 1'b1;
    lcnt_n = !PSW_i ? '0 : (tick && lcnt != L_END) ? lcnt + 1'b1 : lcnt;
    st_n = !fly ? '0 : !tick ? st : st == S_END ? '0 : st + 1'b1;
    snd_n = fly & (snd ^ (tick & (st == S_END)));
    state_n = state;
    msl_n = msl;
    emp_n = emp;
    emp_h = emp;
    score_n = score;
    mt_n = mt;
    et_n = et;
    pt_n = pt;
    case (state)
      IDLE: if (press) begin
        state_n = PLAY;
        msl_n = '0;
        emp_n = '1;
        score_n = '0;
        mt_n = '0;
        et_n = '0;
        pt_n = '0;
      end
      PLAY: begin
        if (msl == '0) begin
          if (press) begin
            msl_n = C_MSL_N'(1);
            mt_n = '0;
          end
        end else if (tick) begin
          mt_n = mt == M_END ? '0 : mt + 1'b1;
          if (mt == M_END) begin
            msl_n = msl << 1;
            if (msl[C_MSL_N-1] && emp[C_EMP_N-1]) begin
              emp_h[C_EMP_N-1] = 1'b0;
              score_n = score + {7'd0, score != 8'hff};
            end
          end
        end
        et_n = tick ? (et == E_END ? '0 : et + 1'b1) : et;
        pt_n = tick && pt != T_END ? pt + 1'b1 : pt;
        // rotation acts on the vector after any hit has cleared its cell
        emp_n = tick && et == E_END ? {emp_h[C_EMP_N-2:0], emp_h[C_EMP_N-1]} : emp_h;
        if (emp_n == '0 || (tick && pt == T_END)) begin
          state_n = OVER;
          msl_n = '0;
        end
      end
      OVER: if (press) state_n = IDLE;
      default: begin
        state_n = IDLE;
        msl_n = '0;
      end
    endcase
    if (long_hit) begin
      state_n = IDLE;
      msl_n = '0;
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state <= IDLE;
      pdiv <= '0;
      mt <= '0;
      et <= '0;
      st <= '0;
      lcnt <= '0;
      pt <= '0;
      msl <= '0;
      emp <= '0;
      score <= '0;
      snd <= 1'b0;
      psw_q <= 1'b0;
    end else begin
      state <= state_n;
      pdiv <= pdiv_n;
      mt <= mt_n;
      et <= et_n;
      st <= st_n;
      lcnt <= lcnt_n;
      pt <= pt_n;
      msl <= msl_n;
      emp <= emp_n;
      score <= score_n;
      snd <= snd_n;
      psw_q <= PSW_i;
    end
  end

  assign MSL_o = msl;
  assign EMP_o = emp;
  assign SCORE_o = score;
  assign STATE_o = state;
  assign SOUND_o = snd;
endmodule

// File: tb/tb_planet_emp_gen.sv
// tb_planet_emp_gen: randomized game play against a tick-level behavioural model of the game rules.
module tb_planet_emp_gen;
  localparam int PDIV = 2, MN = 4, EN = 4, MSTEP = 3, ESTEP = 5, HALF = 1, LONG = 20, PMAX = 200;

  logic          CK_i = 1'b0;
  logic          ARST_i = 1'b1;
  logic          PSW_i = 1'b0;
  logic [MN-1:0] MSL_o;
  logic [EN-1:0] EMP_o;
  logic [7:0]    SCORE_o;
  logic [1:0]    STATE_o;
  logic          SOUND_o;

  int n_chk, n_fail;
  int ms, pos, k, ptk, hold, cyc, score;
  logic [EN-1:0] memp;
  bit prev, msnd, last_tick;

  planet_emp_gen #(
    .C_PDIV_N(PDIV), .C_MSL_N(MN), .C_EMP_N(EN), .C_MSL_STEP_N(MSTEP),
    .C_EMP_STEP_N(ESTEP), .C_SND_HALF_N(HALF), .C_LONG_N(LONG), .C_PLAY_MAX_N(PMAX)
  ) dut (
    .CK_i(CK_i), .ARST_i(ARST_i), .PSW_i(PSW_i), .MSL_o(MSL_o),
    .EMP_o(EMP_o), .SCORE_o(SCORE_o), .STATE_o(STATE_o), .SOUND_o(SOUND_o)
  );

  always #5 CK_i = ~CK_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; pos = -1; k = 0; ptk = 0; hold = 0; cyc = 0; score = 0;
    memp = '0; prev = 1'b0; msnd = 1'b0; last_tick = 1'b0;
  endtask

  // one clock edge of the game rules, with p the switch level seen at that edge
  task automatic step(input bit p);
    bit press, fly;
    int nst;
    cyc++;
    last_tick = (cyc % PDIV) == 0;
    press = p && !prev && hold < LONG;
    fly = ms == 1 && pos >= 0;
    nst = ms;
    if (ms == 0) begin
      if (press) begin nst = 1; memp = '1; score = 0; pos = -1; ptk = 0; end
    end else if (ms == 1) begin
      if (pos < 0) begin
        if (press) begin pos = 0; k = 0; end
      end else if (last_tick) begin
        k++;
        if (k == MN * MSTEP) begin
          if (memp[EN-1]) begin memp[EN-1] = 1'b0; if (score < 255) score++; end
          pos = -1;
        end else pos = k / MSTEP;
      end
      if (last_tick) begin
        ptk++;
        if (ptk % ESTEP == 0) memp = {memp[EN-2:0], memp[EN-1]};
      end
      if (memp == '0 || ptk == PMAX) begin nst = 2; pos = -1; end
    end else if (press) nst = 0;
    hold = !p ? 0 : hold + (last_tick ? 1 : 0);
    if (p && last_tick && hold == LONG) begin nst = 0; pos = -1; end
    msnd = fly && ((k / HALF) % 2 == 1);
    prev = p;
    ms = nst;
  endtask

  task automatic cmp_all();
    chk("msl", 32'(MSL_o), pos < 0 ? 32'd0 : 32'd1 << pos);
    chk("emp", 32'(EMP_o), 32'(memp));
    chk("score", 32'(SCORE_o), 32'(score));
    chk("state", 32'(STATE_o), 32'(ms));
    chk("sound", 32'(SOUND_o), 32'(msnd));
  endtask

  task automatic cycle(input bit p);
    PSW_i = p;
    @(posedge CK_i);
    step(p);
    @(negedge CK_i);
    cmp_all();
  endtask

  task automatic do_reset();
    ARST_i = 1'b1;
    PSW_i = 1'b0;
    #1;
    chk("arst_msl", 32'(MSL_o), 0);
    chk("arst_emp", 32'(EMP_o), 0);
    chk("arst_score", 32'(SCORE_o), 0);
    chk("arst_state", 32'(STATE_o), 0);
    chk("arst_sound", 32'(SOUND_o), 0);
    model_reset();
    @(negedge CK_i);
    ARST_i = 1'b0;
    cmp_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    bit got;
    n_chk = 0;
    n_fail = 0;
    model_reset();
    repeat (2) @(negedge CK_i);
    ARST_i = 1'b0;
    cmp_all();
    cycle(1);
    cycle(0);
    chk("start_state", 32'(STATE_o), 1);
    chk("start_emp", 32'(EMP_o), 32'hF);
    chk("start_score", 32'(SCORE_o), 0);
    chk("start_msl", 32'(MSL_o), 0);
    cycle(1);
    repeat (6) cycle(0);
    cycle(1);
    repeat (30) cycle(0);
    chk("first_hit_score", 32'(SCORE_o), 1);
    chk("first_hit_msl", 32'(MSL_o), 0);

    do_reset();
    cycle(1);
    repeat (45) cycle(1);
    chk("long_state", 32'(STATE_o), 0);
    chk("long_msl", 32'(MSL_o), 0);
    cycle(0);

    do_reset();
    cycle(1);
    n = 0;
    for (int i = 0; i < 600 && STATE_o == 2'd1; i++) begin
      cycle(0);
      if (last_tick) n++;
    end
    chk("timeout_ticks", 32'(n), 32'(PMAX));
    chk("timeout_state", 32'(STATE_o), 2);

    got = 1'b0;
    for (int g = 0; g < 10 && !got; g++) begin
      do_reset();
      cycle(1);
      cycle(0);
      for (int i = 0; i < 800 && STATE_o == 2'd1; i++) begin
        if (MSL_o == '0) begin
          cycle(1);
          cycle(0);
          repeat (int'($urandom_range(0, 3))) cycle(0);
        end else cycle(0);
      end
      got = EMP_o == '0;
    end
    chk("four_hits", 32'(got), 1);
    if (got) begin
      chk("four_hits_score", 32'(SCORE_o), 4);
      chk("four_hits_state", 32'(STATE_o), 2);
      cycle(1);
      cycle(0);
      chk("over_press", 32'(STATE_o), 0);
    end

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) do_reset();
      else if (r < 4) repeat (int'($urandom_range(5, 50))) cycle(1);
      else cycle(r < 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
